riscv_hwloop_controller_seq: RTL and testbench
==============================================

# riscv_hwloop_controller_seq

Sequential hardware-loop controller sitting between the IF stage and the hardware-loop register file. It watches the PC of each instruction handed from IF to ID, detects the last instruction of an active loop, and issues two outputs. The first is a registered redirect request to the loop start address, held until IF accepts it. The second is a one-cycle, one-hot decrement pulse that feeds the register file's decrement input. Innermost-loop priority and back-to-back end matches are resolved here.

## Interface

Parameters:
- N_REGS, 2: number of hardware loops.
- N_REG_BITS, $clog2(N_REGS): loop index width.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- current_pc_i  in  32  PC of the instruction leaving IF.
- pc_valid_i  in  1  instruction at current_pc_i is accepted by ID this cycle.
- hwlp_start_addr_i  in  N_REGS×32  loop start addresses.
- hwlp_end_addr_i  in  N_REGS×32  address of the last body instruction.
- hwlp_counter_i  in  N_REGS×32  remaining iterations.
- hwlp_flush_i  in  1  branch, jump or exception in ID; cancels loop action.
- jump_req_o  out  1  redirect request to IF.
- jump_target_o  out  32  redirect address.
- jump_ack_i  in  1  IF accepts the redirect this cycle.
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement pulse to the register file.

## Operation

- FSM states, defined as an enum:
  - IDLE: evaluates matches.
  - JUMP_PEND: holds the request.
- Loop k matches when all of these hold: pc_valid_i, current_pc_i == hwlp_end_addr_i[k], effective count eff[k] != 0.
- eff[k] = hwlp_counter_i[k] − dec_q[k]. This is 32-bit unsigned arithmetic, and dec_q is the registered pulse.
  - The correction covers the cycle before the register file has applied the decrement.
  - This case arises with a 1-instruction loop body, or a fall-through followed immediately by a re-match.
- Multiple simultaneous matches: the lowest index wins (innermost loop). Only that loop acts.
- Action on a winning match for loop k in IDLE:
  - Always: the next-cycle hwlp_dec_cnt_o has bit k set.
  - If eff[k] > 1: jump_target_o is loaded with hwlp_start_addr_i[k] and the FSM goes to JUMP_PEND.
  - If eff[k] == 1: fall through. The count is decremented to 0 and no jump is issued.
- JUMP_PEND:
  - jump_req_o = 1 and jump_target_o is stable.
  - pc_valid_i is ignored and no matches are evaluated.
  - The FSM leaves JUMP_PEND for IDLE on jump_ack_i or on hwlp_flush_i.
- hwlp_flush_i in IDLE, same cycle as a match: flush wins. There is no decrement and no jump.
- hwlp_flush_i in JUMP_PEND: the request is dropped. The decrement already issued stands, because the end instruction has retired.
- jump_ack_i in IDLE is ignored.
- A match with eff == 0 means the loop is inactive. No action is taken.

## Timing

- Reset values: state IDLE, jump_req_o 0, jump_target_o 0, hwlp_dec_cnt_o 0, dec_q 0.
- A match at cycle t produces hwlp_dec_cnt_o (one cycle) at t+1 and jump_req_o from t+1.
- Ack at t+1 deasserts jump_req_o at t+2. At t+2 the FSM is in IDLE and evaluates new matches.
- jump_req_o is held any number of cycles until ack. jump_target_o does not change while the request is held.
- Reset mid-JUMP_PEND: the request drops asynchronously and nothing is replayed.
- hwlp_dec_cnt_o never has more than one bit set.

## Configuration

- RISCV_HWLP_NESTED_EN defined: all N_REGS loops are evaluated with innermost priority.
- Undefined: only loop 0 is evaluated, and hwlp_dec_cnt_o[N_REGS-1:1] is tied 0. Loops above 0 never match.

## Structure

- Shared package riscv_hwlp_pkg contains:
  - hwlp_state_e {IDLE, JUMP_PEND}
  - HWLP_ADDR_W = 32
- Sub-module riscv_hwlp_match is natural. It takes per-loop equality plus eff != 0 and eff > 1, applies the priority encoder, and outputs win_valid, win_idx and win_jump.

## Test plan

- Loop 0 with start 0x100, end 0x10C, count 3, PC 0x10C accepted: dec pulse 01 at t+1, req with target 0x100. Ack same cycle, request gone at t+2. After two more passes the third pass falls through with no req.
- 1-instruction body (start = end = 0x200), count 2: match at t, dec at t+1. Re-match at t+2 uses the corrected count of 1, so it falls through. No stale extra jump.
- Nested loops, loop 0 end = loop 1 end = 0x300, both counts 5: only loop 0 decrements and jumps. With the macro undefined, loop 1 alone with matching end gives no action.
- Flush in the same cycle as a match: no dec, no req. Flush during JUMP_PEND held 3 cycles: req drops next cycle and the dec pulse had already fired once.
- Reset asserted during JUMP_PEND: all outputs 0 immediately, and IDLE after release.

Source files
------------

// File: rtl/riscv_hwlp_pkg.sv
// Shared definitions for the hardware-loop controller slice.
// Used by riscv_hwlp_match and riscv_hwloop_controller_seq.
package riscv_hwlp_pkg;

   // Width of loop start/end addresses and iteration counters.
   localparam int unsigned HWLP_ADDR_W = 32;

   // Controller FSM states.
   // IDLE evaluates end-of-loop matches.
   // JUMP_PEND holds the redirect request until IF accepts it.
   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      JUMP_PEND = 1'b1
   } hwlp_state_e;

   // Returns a one-hot vector with bit idx set, or all zeros when valid is low.
   function automatic logic [31:0] hwlp_onehot(input logic valid, input int unsigned idx);
      logic [31:0] v;
      v = '0;
      if (valid) begin
         v[idx] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/riscv_hwlp_match.sv
// Priority selection among per-loop end-address matches.
// The lowest-index candidate wins, so the innermost loop takes precedence.
// A candidate requires the loop to be enabled, its end address to equal the
// accepted PC, and its effective count to be non-zero. o_win_jump reports
// whether the winner still has more than one iteration left, which means
// a redirect is needed.
module riscv_hwlp_match
   import riscv_hwlp_pkg::*;
#(
   parameter int unsigned N_REGS     = 2,
   parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
   input  logic [N_REGS-1:0]     i_loop_en,
   input  logic [N_REGS-1:0]     i_end_eq,
   input  logic [N_REGS-1:0]     i_eff_nz,
   input  logic [N_REGS-1:0]     i_eff_gt1,
   output logic                  o_win_valid,
   output logic [N_REG_BITS-1:0] o_win_idx,
   output logic                  o_win_jump
);

   logic [N_REGS-1:0] w_cand;

   // A loop is a candidate only when enabled, end-address equal and still active.
   always_comb begin
      w_cand = i_loop_en & i_end_eq & i_eff_nz;
   end

   // Priority encoder: the first (lowest-index) candidate wins.
   always_comb begin
      o_win_valid = 1'b0;
      o_win_idx   = '0;
      o_win_jump  = 1'b0;
      for (int unsigned k = 0; k < N_REGS; k++) begin
         if (!o_win_valid && w_cand[k]) begin
            o_win_valid = 1'b1;
            o_win_idx   = N_REG_BITS'(k);
            o_win_jump  = i_eff_gt1[k];
         end
      end
   end

endmodule

// File: rtl/riscv_hwloop_controller_seq.sv
// Sequential hardware-loop controller between IF and the hwloop register file.
//
// The block detects the last instruction of an active loop and reacts in two ways:
//   - It issues a registered redirect to the loop start, held until IF acks.
//   - It issues a one-cycle, one-hot decrement pulse to the register file.
//
// Configuration macro: RISCV_HWLP_NESTED_EN.
//   Defined:   all N_REGS loops are evaluated, with innermost priority.
//   Undefined: only loop 0 is evaluated, and the upper decrement bits are tied to 0.
module riscv_hwloop_controller_seq
   import riscv_hwlp_pkg::*;
#(
   parameter int unsigned N_REGS     = 2,
   parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [HWLP_ADDR_W-1:0]               current_pc_i,
   input  logic                                 pc_valid_i,
   input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0]   hwlp_start_addr_i,
   input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0]   hwlp_end_addr_i,
   input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0]   hwlp_counter_i,
   input  logic                                 hwlp_flush_i,
   output logic                                 jump_req_o,
   output logic [HWLP_ADDR_W-1:0]               jump_target_o,
   input  logic                                 jump_ack_i,
   output logic [N_REGS-1:0]                    hwlp_dec_cnt_o
);

   hwlp_state_e                         r_state;
   logic                                r_jump_req;
   logic [HWLP_ADDR_W-1:0]              r_jump_target;
   logic [N_REGS-1:0]                   r_dec_q;

   logic [N_REGS-1:0]                   w_loop_en;
   logic [N_REGS-1:0][HWLP_ADDR_W-1:0]  w_eff;
   logic [N_REGS-1:0]                   w_end_eq;
   logic [N_REGS-1:0]                   w_eff_nz;
   logic [N_REGS-1:0]                   w_eff_gt1;
   logic                                w_win_valid;
   logic [N_REG_BITS-1:0]               w_win_idx;
   logic                                w_win_jump;
   logic [N_REGS-1:0]                   w_win_onehot;

`ifdef RISCV_HWLP_NESTED_EN
   assign w_loop_en = '1;
`else
   assign w_loop_en = N_REGS'(1);
`endif

   // Per-loop match terms.
   // The effective count subtracts the decrement still in flight to the
   // register file, so a re-match in the cycle right after a pulse sees the
   // post-decrement count.
   always_comb begin
      w_eff     = '0;
      w_end_eq  = '0;
      w_eff_nz  = '0;
      w_eff_gt1 = '0;
      for (int unsigned k = 0; k < N_REGS; k++) begin
         w_eff[k]     = hwlp_counter_i[k] - HWLP_ADDR_W'(r_dec_q[k]);
         w_end_eq[k]  = pc_valid_i && (current_pc_i == hwlp_end_addr_i[k]);
         w_eff_nz[k]  = (w_eff[k] != '0);
         w_eff_gt1[k] = (w_eff[k] > HWLP_ADDR_W'(1));
      end
   end

   riscv_hwlp_match #(
      .N_REGS     (N_REGS),
      .N_REG_BITS (N_REG_BITS)
   ) u_match (
      .i_loop_en   (w_loop_en),
      .i_end_eq    (w_end_eq),
      .i_eff_nz    (w_eff_nz),
      .i_eff_gt1   (w_eff_gt1),
      .o_win_valid (w_win_valid),
      .o_win_idx   (w_win_idx),
      .o_win_jump  (w_win_jump)
   );

   // Expand the winning index into a one-hot decrement vector, limited to enabled loops.
   always_comb begin
      w_win_onehot = N_REGS'(hwlp_onehot(w_win_valid, 32'(w_win_idx))) & w_loop_en;
   end

   // Controller FSM with registered redirect and decrement outputs.
   // A flush in IDLE suppresses the whole action.
   // A flush in JUMP_PEND only drops the request, because the decrement has
   // already been issued for a retired end instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_jump_req    <= 1'b0;
         r_jump_target <= '0;
         r_dec_q       <= '0;
      end else begin
         r_dec_q <= '0;
         case (r_state)
            IDLE: begin
               if (!hwlp_flush_i && w_win_valid) begin
                  r_dec_q <= w_win_onehot;
                  if (w_win_jump) begin
                     r_jump_target <= hwlp_start_addr_i[w_win_idx];
                     r_jump_req    <= 1'b1;
                     r_state       <= JUMP_PEND;
                  end
               end
            end
            JUMP_PEND: begin
               if (jump_ack_i || hwlp_flush_i) begin
                  r_jump_req <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_jump_req <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign jump_req_o     = r_jump_req;
   assign jump_target_o  = r_jump_target;
   assign hwlp_dec_cnt_o = r_dec_q & w_loop_en;

endmodule

// File: tb/tb_riscv_hwloop_controller_seq.sv
// Self-checking bench for riscv_hwloop_controller_seq.
// The hwloop register file is modelled here: a loop's counter drops by one at
// the clock edge where the DUT's decrement pulse is high.
module tb_riscv_hwloop_controller_seq;

   localparam int N = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       pc;
   logic              valid;
   logic              flush;
   logic              ack;
   logic [N-1:0][31:0] st;
   logic [N-1:0][31:0] en;
   logic [N-1:0][31:0] cnt;
   logic              req;
   logic [31:0]       tgt;
   logic [N-1:0]      dec;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic        req;
      logic [31:0] tgt;
      logic [1:0]  dec;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   riscv_hwloop_controller_seq #(
      .N_REGS (N)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .current_pc_i      (pc),
      .pc_valid_i        (valid),
      .hwlp_start_addr_i (st),
      .hwlp_end_addr_i   (en),
      .hwlp_counter_i    (cnt),
      .hwlp_flush_i      (flush),
      .jump_req_o        (req),
      .jump_target_o     (tgt),
      .jump_ack_i        (ack),
      .hwlp_dec_cnt_o    (dec)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, queue the expected outputs, then check after the edge.
   task automatic step(input string tag, input logic [31:0] p, input logic v, input logic f,
                       input logic a, input logic er, input logic [31:0] et, input logic [1:0] ed);
      exp_t        e;
      string       t;
      logic [N-1:0] prev;
      @(negedge clk);
      pc    = p;
      valid = v;
      flush = f;
      ack   = a;
      e.req = er;
      e.tgt = et;
      e.dec = ed;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      prev = dec;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (prev[k]) cnt[k] = cnt[k] - 32'd1;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".req"}, 32'(req), 32'(e.req));
      chk({t, ".dec"}, 32'(dec), 32'(e.dec));
      if (e.req) chk({t, ".tgt"}, tgt, e.tgt);
   endtask

   initial begin
      rst   = 1'b1;
      pc    = '0;
      valid = 1'b0;
      flush = 1'b0;
      ack   = 1'b0;
      st    = '0;
      en    = {32'hFFFF_0000, 32'hFFFF_0000};
      cnt   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req", 32'(req), 32'd0);
      chk("rst.tgt", tgt, 32'd0);
      chk("rst.dec", 32'(dec), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Loop 0, three iterations: two jumps, then a fall-through.
      st[0] = 32'h100; en[0] = 32'h10C; cnt[0] = 32'd3; cnt[1] = 32'd0;
      step("t1.m1",   32'h10C, 1, 0, 0, 1, 32'h100, 2'b01);
      step("t1.ack1", 32'h110, 0, 0, 1, 0, 32'h0,   2'b00);
      step("t1.m2",   32'h10C, 1, 0, 0, 1, 32'h100, 2'b01);
      step("t1.ack2", 32'h110, 0, 0, 1, 0, 32'h0,   2'b00);
      step("t1.ft",   32'h10C, 1, 0, 0, 0, 32'h0,   2'b01);
      step("t1.rem",  32'h10C, 1, 0, 0, 0, 32'h0,   2'b00);
      step("t1.dead", 32'h10C, 1, 0, 0, 0, 32'h0,   2'b00);
      step("t1.ackidle", 32'h0, 0, 0, 1, 0, 32'h0,  2'b00);
      chk("t1.cnt", cnt[0], 32'd0);

      // Single-instruction body, count 2.
      st[0] = 32'h200; en[0] = 32'h200; cnt[0] = 32'd2;
      step("t2.m",    32'h200, 1, 0, 0, 1, 32'h200, 2'b01);
      step("t2.ack",  32'h200, 1, 0, 1, 0, 32'h0,   2'b00);
      step("t2.ft",   32'h200, 1, 0, 0, 0, 32'h0,   2'b01);
      step("t2.rem",  32'h200, 1, 0, 0, 0, 32'h0,   2'b00);
      chk("t2.cnt", cnt[0], 32'd0);

      // Nested loops sharing one end address: the innermost loop wins.
      st[0] = 32'h2F0; en[0] = 32'h300; cnt[0] = 32'd5;
      st[1] = 32'h280; en[1] = 32'h300; cnt[1] = 32'd5;
      step("t3.m",    32'h300, 1, 0, 0, 1, 32'h2F0, 2'b01);
      step("t3.ack",  32'h0,   0, 0, 1, 0, 32'h0,   2'b00);
      chk("t3.cnt0", cnt[0], 32'd4);
      chk("t3.cnt1", cnt[1], 32'd5);
      en[0] = 32'h404;
`ifdef RISCV_HWLP_NESTED_EN
      step("t3.l1",    32'h300, 1, 0, 0, 1, 32'h280, 2'b10);
`else
      step("t3.l1",    32'h300, 1, 0, 0, 0, 32'h0,   2'b00);
`endif
      step("t3.l1ack", 32'h0,   0, 0, 1, 0, 32'h0,   2'b00);
      cnt[1] = 32'd0;

      // Flush in the same cycle as a match, then a flush while the request is pending.
      st[0] = 32'h3C0; en[0] = 32'h400; cnt[0] = 32'd5;
      step("t4.fm",   32'h400, 1, 1, 0, 0, 32'h0,   2'b00);
      step("t4.m",    32'h400, 1, 0, 0, 1, 32'h3C0, 2'b01);
      step("t4.h1",   32'h400, 1, 0, 0, 1, 32'h3C0, 2'b00);
      step("t4.h2",   32'h0,   0, 0, 0, 1, 32'h3C0, 2'b00);
      step("t4.fl",   32'h0,   0, 1, 0, 0, 32'h0,   2'b00);
      step("t4.idle", 32'h0,   0, 0, 1, 0, 32'h0,   2'b00);
      chk("t4.cnt", cnt[0], 32'd4);

      // Reset while the request is pending.
      st[0] = 32'h4F0; en[0] = 32'h500; cnt[0] = 32'd3;
      step("t5.m", 32'h500, 1, 0, 0, 1, 32'h4F0, 2'b01);
      @(negedge clk);
      valid = 1'b0;
      rst   = 1'b1;
      #1;
      chk("t5.rst.req", 32'(req), 32'd0);
      chk("t5.rst.tgt", tgt, 32'd0);
      chk("t5.rst.dec", 32'(dec), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step("t5.idle", 32'h0,   0, 0, 0, 0, 32'h0,   2'b00);
      chk("t5.cnt", cnt[0], 32'd3);
      step("t5.m2",   32'h500, 1, 0, 0, 1, 32'h4F0, 2'b01);
      step("t5.ack",  32'h0,   0, 0, 1, 0, 32'h0,   2'b00);
      chk("t5.cnt2", cnt[0], 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
